// File: rtl/tx_message_buffer.sv
// Transmit message buffer: a TX FIFO plus a single-entry high-priority buffer (HPB)
// feeding the CAN core over valid/ready. Optional macro TX_BUF_OVF_FLAG_EN adds ovf_flag/ovf_clr.
module tx_message_buffer #(
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                sys_clk,
  input  logic                IP2Can_reset,
  input  logic                fifo_wr_en,
  input  logic [WORD_W-1:0]   fifo_id,
  input  logic [WORD_W-1:0]   fifo_dlc,
  input  logic [WORD_W-1:0]   fifo_dw1,
  input  logic [WORD_W-1:0]   fifo_dw2,
  input  logic                hpb_wr_en,
  input  logic [WORD_W-1:0]   hpb_id,
  input  logic [WORD_W-1:0]   hpb_dlc,
  input  logic [WORD_W-1:0]   hpb_dw1,
  input  logic [WORD_W-1:0]   hpb_dw2,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic [LVL_W-1:0]    fifo_level,
  output logic                hpb_full,
  output logic [4*WORD_W-1:0] tx_msg,
  output logic                tx_valid,
  output logic                tx_src,
`ifdef TX_BUF_OVF_FLAG_EN
  input  logic                ovf_clr,
  output logic                ovf_flag,
`endif
  input  logic                tx_ready
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int MSG_W = 4 * WORD_W;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  logic [MSG_W-1:0] mem_q [FIFO_DEPTH];
  logic [MSG_W-1:0] hpb_msg_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             hpb_full_q, hpb_full_d;
  state_e           state_q;
  logic [MSG_W-1:0] tx_msg_q;
  logic             tx_valid_q;
  logic             tx_src_q;

  logic             full_w;
  logic             empty_w;
  logic             fifo_push;
  logic             fifo_pop;
  logic             hpb_load;
  logic             hpb_take;

  assign full_w  = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty_w = (level_q == '0);

  // Acceptance decisions all use pre-edge status, so a same-cycle drain never frees a slot early.
  assign fifo_push = fifo_wr_en & ~full_w;
  assign hpb_load  = hpb_wr_en & ~hpb_full_q;
  assign hpb_take  = (state_q == IDLE) & hpb_full_q;
  assign fifo_pop  = (state_q == IDLE) & ~hpb_full_q & ~empty_w;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (fifo_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (fifo_push && !fifo_pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (fifo_pop && !fifo_push) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  always_comb begin
    hpb_full_d = hpb_full_q;
    if (hpb_take) begin
      hpb_full_d = 1'b0;
    end else if (hpb_load) begin
      hpb_full_d = 1'b1;
    end
  end

  // Message storage carries no reset: the level counter and hpb_full gate its visibility.
  always_ff @(posedge sys_clk) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q] <= {fifo_id, fifo_dlc, fifo_dw1, fifo_dw2};
    end
    if (hpb_load) begin
      hpb_msg_q <= {hpb_id, hpb_dlc, hpb_dw1, hpb_dw2};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (IP2Can_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      hpb_full_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      hpb_full_q <= hpb_full_d;
    end
  end

  // Output FSM: HPB wins in IDLE; PRESENT holds the message until the core takes it.
  always_ff @(posedge sys_clk) begin
    if (IP2Can_reset) begin
      state_q    <= IDLE;
      tx_msg_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_src_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hpb_full_q) begin
            tx_msg_q   <= hpb_msg_q;
            tx_src_q   <= 1'b1;
            tx_valid_q <= 1'b1;
            state_q    <= PRESENT;
          end else if (!empty_w) begin
            tx_msg_q   <= mem_q[rd_ptr_q];
            tx_src_q   <= 1'b0;
            tx_valid_q <= 1'b1;
            state_q    <= PRESENT;
          end
        end
        PRESENT: begin
          if (tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

`ifdef TX_BUF_OVF_FLAG_EN
  logic ovf_q;
  logic drop_w;

  assign drop_w = (fifo_wr_en & full_w) | (hpb_wr_en & hpb_full_q);

  // A drop in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge sys_clk) begin
    if (IP2Can_reset) begin
      ovf_q <= 1'b0;
    end else if (drop_w) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf_flag = ovf_q;
`endif

  assign fifo_full  = full_w;
  assign fifo_empty = empty_w;
  assign fifo_level = level_q;
  assign hpb_full   = hpb_full_q;
  assign tx_msg     = tx_msg_q;
  assign tx_valid   = tx_valid_q;
  assign tx_src     = tx_src_q;

endmodule

// File: tb/tb_tx_message_buffer.sv
// Bench for tx_message_buffer: queue-based reference model, hand-derived vector table and corner sequences.
module tb_tx_message_buffer;

  localparam int WORD_W = 32;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               fwr, hwr, rdy, clr;
  logic [127:0]       f_msg, h_msg;
  logic               fifo_full, fifo_empty, hpb_full, tx_valid, tx_src;
  logic [LVL_W-1:0]   fifo_level;
  logic [127:0]       tx_msg;
  logic               ovf_flag_w;

  always #5 clk = ~clk;

  tx_message_buffer #(.WORD_W(WORD_W), .FIFO_DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .sys_clk      (clk),
    .IP2Can_reset (rst),
    .fifo_wr_en   (fwr),
    .fifo_id      (f_msg[127:96]),
    .fifo_dlc     (f_msg[95:64]),
    .fifo_dw1     (f_msg[63:32]),
    .fifo_dw2     (f_msg[31:0]),
    .hpb_wr_en    (hwr),
    .hpb_id       (h_msg[127:96]),
    .hpb_dlc      (h_msg[95:64]),
    .hpb_dw1      (h_msg[63:32]),
    .hpb_dw2      (h_msg[31:0]),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_level   (fifo_level),
    .hpb_full     (hpb_full),
    .tx_msg       (tx_msg),
    .tx_valid     (tx_valid),
    .tx_src       (tx_src),
`ifdef TX_BUF_OVF_FLAG_EN
    .ovf_clr      (clr),
    .ovf_flag     (ovf_flag_w),
`endif
    .tx_ready     (rdy)
  );

`ifndef TX_BUF_OVF_FLAG_EN
  assign ovf_flag_w = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: pending FIFO messages, HPB slot, presented message, overflow flag.
  logic [127:0] mq [$];
  bit           m_hv;
  logic [127:0] m_hmsg;
  bit           m_pv;
  bit           m_src;
  logic [127:0] m_pmsg;
  bit           m_ovf;

  typedef struct {
    logic        fwr;
    logic [31:0] fid;
    logic        hwr;
    logic [31:0] hid;
    logic        rdy;
    logic        e_valid;
    logic        e_src;
    logic [31:0] e_id;
    int          e_level;
    logic        e_hfull;
  } vec_t;

  vec_t tbl [$];

  function automatic logic [127:0] msg_of(input logic [31:0] id);
    return {id, 32'd8, id ^ 32'hA5A5_0000, ~id};
  endfunction

  function automatic vec_t mk(input logic fw, input logic [31:0] fi, input logic hw, input logic [31:0] hi,
                              input logic r, input logic ev, input logic es, input logic [31:0] ei,
                              input int el, input logic eh);
    vec_t v;
    v.fwr = fw; v.fid = fi; v.hwr = hw; v.hid = hi; v.rdy = r;
    v.e_valid = ev; v.e_src = es; v.e_id = ei; v.e_level = el; v.e_hfull = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock: update the model from the current inputs, then compare after the edge.
  task automatic cycle();
    int pre_sz;
    bit pre_hv;
    bit drop;
    if (rst) begin
      mq.delete();
      m_hv = 0; m_pv = 0; m_src = 0; m_pmsg = '0; m_ovf = 0;
    end else begin
      pre_sz = mq.size();
      pre_hv = m_hv;
      drop = (fwr && pre_sz == DEPTH) || (hwr && pre_hv);
      if (!m_pv) begin
        if (m_hv) begin
          m_pv = 1; m_src = 1; m_pmsg = m_hmsg; m_hv = 0;
        end else if (mq.size() > 0) begin
          m_pv = 1; m_src = 0; m_pmsg = mq.pop_front();
        end
      end else if (rdy) begin
        m_pv = 0;
      end
      if (fwr && pre_sz < DEPTH) mq.push_back(f_msg);
      if (hwr && !pre_hv) begin
        m_hv = 1; m_hmsg = h_msg;
      end
      if (drop) m_ovf = 1;
      else if (clr) m_ovf = 0;
    end
    @(posedge clk);
    #1;
    chk("model_level", 128'(fifo_level), 128'(mq.size()));
    chk("model_full_empty", 128'({fifo_full, fifo_empty}), 128'({mq.size() == DEPTH, mq.size() == 0}));
    chk("model_hpb_full", 128'(hpb_full), 128'(m_hv));
    chk("model_tx_valid", 128'(tx_valid), 128'(m_pv));
    if (m_pv) begin
      chk("model_tx_src", 128'(tx_src), 128'(m_src));
      chk("model_tx_msg", tx_msg, m_pmsg);
    end
`ifdef TX_BUF_OVF_FLAG_EN
    chk("model_ovf_flag", 128'(ovf_flag_w), 128'(m_ovf));
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; fwr = 0; hwr = 0; rdy = 0; clr = 0; f_msg = '0; h_msg = '0;
    #1;
    cycle();
    cycle();
    chk("reset_outputs", {tx_msg}, 128'd0);
    chk("reset_flags", 128'({tx_valid, tx_src, hpb_full, fifo_full, fifo_empty, fifo_level}), 128'(7'b0000_1_000));
    rst = 0;

    // Single message with the core always ready.
    rdy = 1; fwr = 1;
    f_msg = {32'h0000_0123, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0102_0304};
    cycle();
    chk("first_level1", 128'(fifo_level), 128'd1);
    chk("first_not_yet_valid", 128'(tx_valid), 128'd0);
    fwr = 0;
    cycle();
    chk("first_valid", 128'(tx_valid), 128'd1);
    chk("first_msg", tx_msg, 128'h00000123_00000008_DEADBEEF_01020304);
    chk("first_src", 128'(tx_src), 128'd0);
    chk("first_level0", 128'(fifo_level), 128'd0);
    cycle();
    chk("first_accepted", 128'(tx_valid), 128'd0);

    // Overflow with a held head message, then the priority ordering case.
    tbl.push_back(mk(1, 32'hF0, 0, 0, 0, 0, 0, 0,      1, 0));
    tbl.push_back(mk(1, 32'h01, 0, 0, 0, 1, 0, 32'hF0, 1, 0));
    tbl.push_back(mk(1, 32'h02, 0, 0, 0, 1, 0, 32'hF0, 2, 0));
    tbl.push_back(mk(1, 32'h03, 0, 0, 0, 1, 0, 32'hF0, 3, 0));
    tbl.push_back(mk(1, 32'h04, 0, 0, 0, 1, 0, 32'hF0, 4, 0));
    tbl.push_back(mk(1, 32'h05, 0, 0, 0, 1, 0, 32'hF0, 4, 0));
    tbl.push_back(mk(0, 0,      0, 0, 1, 0, 0, 0,      4, 0));
    tbl.push_back(mk(0, 0,      0, 0, 1, 1, 0, 32'h01, 3, 0));
    tbl.push_back(mk(0, 0,      0, 0, 1, 0, 0, 0,      3, 0));
    tbl.push_back(mk(0, 0,      0, 0, 1, 1, 0, 32'h02, 2, 0));
    tbl.push_back(mk(0, 0,      0, 0, 1, 0, 0, 0,      2, 0));
    tbl.push_back(mk(0, 0,      0, 0, 1, 1, 0, 32'h03, 1, 0));
    tbl.push_back(mk(0, 0,      0, 0, 1, 0, 0, 0,      1, 0));
    tbl.push_back(mk(0, 0,      0, 0, 1, 1, 0, 32'h04, 0, 0));
    tbl.push_back(mk(0, 0,      0, 0, 1, 0, 0, 0,      0, 0));
    tbl.push_back(mk(0, 0,      0, 0, 1, 0, 0, 0,      0, 0));
    tbl.push_back(mk(1, 32'h10, 0, 0,       0, 0, 0, 0,       1, 0));
    tbl.push_back(mk(1, 32'h11, 0, 0,       0, 1, 0, 32'h10,  1, 0));
    tbl.push_back(mk(0, 0,      1, 32'h7FF, 0, 1, 0, 32'h10,  1, 1));
    tbl.push_back(mk(0, 0,      0, 0,       0, 1, 0, 32'h10,  1, 1));
    tbl.push_back(mk(0, 0,      0, 0,       1, 0, 0, 0,       1, 1));
    tbl.push_back(mk(0, 0,      0, 0,       1, 1, 1, 32'h7FF, 1, 0));
    tbl.push_back(mk(0, 0,      0, 0,       1, 0, 0, 0,       1, 0));
    tbl.push_back(mk(0, 0,      0, 0,       1, 1, 0, 32'h11,  0, 0));
    tbl.push_back(mk(0, 0,      0, 0,       0, 1, 0, 32'h11,  0, 0));
    tbl.push_back(mk(0, 0,      0, 0,       1, 0, 0, 0,       0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      fwr = tbl[i].fwr; f_msg = msg_of(tbl[i].fid);
      hwr = tbl[i].hwr; h_msg = msg_of(tbl[i].hid);
      rdy = tbl[i].rdy;
      cycle();
      chk($sformatf("vec%0d_valid", i), 128'(tx_valid), 128'(tbl[i].e_valid));
      chk($sformatf("vec%0d_level", i), 128'(fifo_level), 128'(tbl[i].e_level));
      chk($sformatf("vec%0d_hpb_full", i), 128'(hpb_full), 128'(tbl[i].e_hfull));
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d_src", i), 128'(tx_src), 128'(tbl[i].e_src));
        chk($sformatf("vec%0d_msg", i), tx_msg, msg_of(tbl[i].e_id));
      end
    end
    fwr = 0; hwr = 0;
`ifdef TX_BUF_OVF_FLAG_EN
    chk("ovf_after_drop", 128'(ovf_flag_w), 128'd1);
    clr = 1; cycle(); clr = 0;
    chk("ovf_cleared", 128'(ovf_flag_w), 128'd0);
`endif

    // Long stall on a FIFO message while the HPB is loaded behind it.
    rdy = 0; fwr = 1; f_msg = msg_of(32'h55);
    cycle();
    fwr = 0;
    cycle();
    hwr = 1; h_msg = msg_of(32'h66);
    cycle();
    hwr = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (i % 5 == 4) begin
        chk("hold_msg", tx_msg, msg_of(32'h55));
        chk("hold_src_valid", 128'({tx_src, tx_valid}), 128'(2'b01));
      end
    end
    rdy = 1;
    cycle();
    chk("hold_released", 128'(tx_valid), 128'd0);
    cycle();
    chk("hpb_follows_valid", 128'({tx_src, tx_valid}), 128'(2'b11));
    chk("hpb_follows_msg", tx_msg, msg_of(32'h66));
    cycle();

    // Reset while presenting, with three FIFO entries and a loaded HPB.
    rdy = 0;
    for (int i = 0; i < 4; i++) begin
      fwr = 1; f_msg = msg_of(32'h21 + i);
      cycle();
    end
    fwr = 0; hwr = 1; h_msg = msg_of(32'h77);
    cycle();
    hwr = 0;
    chk("pre_reset_state", 128'({tx_valid, hpb_full, fifo_level}), 128'({1'b1, 1'b1, 3'd3}));
    rst = 1;
    cycle();
    rst = 0;
    chk("midreset_msg", tx_msg, 128'd0);
    chk("midreset_flags", 128'({tx_valid, tx_src, hpb_full, fifo_full, fifo_empty, fifo_level}), 128'(7'b0000_1_000));
    rdy = 1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("no_stale_after_reset", 128'(tx_valid), 128'd0);
    end

    // Pointer wrap: pushes paced against acceptance.
    rdy = 1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      fwr = 1; f_msg = msg_of(32'h100 + i);
      cycle();
      chk("wrap_level_bound", 128'(fifo_level <= 2), 128'd1);
      fwr = 0;
      cycle();
      chk("wrap_level_bound", 128'(fifo_level <= 2), 128'd1);
    end
    for (int i = 0; i < 4; i++) cycle();
    chk("wrap_drained", 128'({fifo_empty, tx_valid}), 128'(2'b10));

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 79) == 0);
      fwr   = ($urandom_range(0, 1) == 1);
      hwr   = ($urandom_range(0, 5) == 0);
      rdy   = ($urandom_range(0, 2) != 0);
      clr   = ($urandom_range(0, 7) == 0);
      f_msg = {$urandom, $urandom, $urandom, $urandom};
      h_msg = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    rst = 0; fwr = 0; hwr = 0; clr = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tx_message_buffer.md
Name: tx_message_buffer

Overview:
- Parametrised transmit message buffer between the register DEMUX and the CAN transmit engine.
- Holds a FIFO of FIFO_DEPTH messages plus a single-entry high-priority buffer (HPB).
- Packs each message as {id, dlc, dataword1, dataword2} and presents one message at a time to the CAN core over a valid/ready handshake.
- When both sources hold a message, the HPB is always selected first.

Parameters:
- WORD_W, 32, width of each message word (id, dlc, dataword1, dataword2).
- FIFO_DEPTH, 4, number of TX FIFO entries; must be a power of 2, minimum 2.
- LVL_W, $clog2(FIFO_DEPTH)+1, width of fifo_level.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- IP2Can_reset  in  1  synchronous, active-high reset.
- fifo_wr_en  in  1  write-strobe: push one FIFO message this cycle.
- fifo_id, fifo_dlc, fifo_dw1, fifo_dw2  in  WORD_W each  FIFO message words.
- hpb_wr_en  in  1  write-strobe: load the HPB this cycle.
- hpb_id, hpb_dlc, hpb_dw1, hpb_dw2  in  WORD_W each  HPB message words.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- fifo_empty  out  1  FIFO holds 0 entries.
- fifo_level  out  LVL_W  current FIFO occupancy.
- hpb_full  out  1  HPB holds a message.
- tx_msg  out  4*WORD_W  presented message as {id, dlc, dw1, dw2}; id occupies the MSBs.
- tx_valid  out  1  tx_msg is valid.
- tx_src  out  1  source of tx_msg: 1 = HPB, 0 = FIFO.
- tx_ready  in  1  the CAN core accepts tx_msg this cycle.

Behaviour:
- Reset: all registered outputs are 0 when IP2Can_reset is sampled high.
  - fifo_empty = 1; fifo_full, fifo_level, hpb_full, tx_valid, tx_src and tx_msg are 0.
  - Read/write pointers are cleared and the output FSM returns to IDLE.
  - Reset mid-transfer discards all stored and presented messages; there is no partial state.
- FIFO write:
  - When fifo_wr_en=1 and fifo_full=0, the four words are stored at wr_ptr and wr_ptr increments.
  - Pointers wrap modulo FIFO_DEPTH; full/empty detection uses an extra pointer MSB or the level counter.
  - fifo_wr_en while fifo_full=1 is silently dropped, even if a FIFO pop occurs in the same cycle.
- HPB write:
  - When hpb_wr_en=1 and hpb_full=0, the message is stored and hpb_full sets next cycle.
  - hpb_wr_en while hpb_full=1 is dropped, even if the HPB is drained in the same cycle.
- Status update: fifo_level, fifo_full, fifo_empty and hpb_full reflect a write or pop in the cycle after it.
  - A simultaneous accepted push and pop leaves the level unchanged.
- Output FSM, state IDLE (tx_valid=0):
  - If hpb_full=1: load the HPB into tx_msg, set tx_src=1, clear hpb_full, go to PRESENT.
  - Else if fifo_empty=0: load the FIFO head into tx_msg, set tx_src=0, pop (rd_ptr++), go to PRESENT.
  - Else stay in IDLE.
- Output FSM, state PRESENT (tx_valid=1):
  - tx_msg and tx_src are held stable until tx_ready=1; no preemption by a later HPB write.
  - On tx_valid & tx_ready, go to IDLE; tx_valid deasserts next cycle.
- Latency and throughput:
  - A write in cycle N makes the message visible in status at N+1; the earliest tx_valid is N+2.
  - Sustained throughput is one message per 2 cycles (one bubble cycle in IDLE).
- tx_ready while tx_valid=0 is ignored.
- Simultaneous write to an empty buffer and selection in the same cycle: the selection sees pre-write state, so the new message waits one cycle.

Optional Feature:
- Macro: TX_BUF_OVF_FLAG_EN.
- Defined: adds two ports.
  - Output ovf_flag, 1 bit, sticky: sets the cycle after any dropped fifo_wr_en or hpb_wr_en.
  - Input ovf_clr, 1 bit: clears ovf_flag next cycle. If a drop and ovf_clr occur together, set wins.
  - ovf_flag resets to 0.
- Not defined: the ports are absent and dropped writes have no indication.

Test Plan:
- Reset, then push FIFO id=0x123 dlc=8 dw1=0xDEADBEEF dw2=0x01020304 with tx_ready=1.
  - tx_valid at write+2 with tx_msg=0x00000123_00000008_DEADBEEF_01020304 and tx_src=0.
  - fifo_level goes 1 then 0.
- Push 5 messages (ids 1..5) with FIFO_DEPTH=4 and tx_ready=0.
  - fifo_full=1, level=4, id 5 dropped.
  - With tx_ready=1: ids 1,2,3,4 are delivered in order, each 2 cycles apart. ovf_flag=1 if TX_BUF_OVF_FLAG_EN.
- Load FIFO ids 0x10 and 0x11, then HPB id 0x7FF, while tx_valid is held by tx_ready=0 on 0x10.
  - Delivery order is 0x10, 0x7FF (tx_src=1), 0x11.
- Hold tx_ready=0 for 20 cycles with tx_valid=1, and write the HPB meanwhile.
  - tx_msg and tx_src stay constant; the HPB message follows immediately after acceptance.
- Assert IP2Can_reset while in PRESENT with FIFO level 3 and hpb_full=1.
  - Next cycle all outputs are 0, fifo_empty=1, and no stale message appears afterwards.
- Run 3×FIFO_DEPTH push/pop pairs with simultaneous push and accept.
  - Pointer wrap is exercised, data integrity holds, and the level stays bounded at ≤2.
